// File: rtl/down_fir_if.sv
// rtl/down_fir_if.sv - input/output frame stream bundle for down_fir
interface down_fir_if #(
  parameter int NCH    = 2,
  parameter int DATA_W = 24
);
  logic                    in_valid;
  logic                    in_ready;
  logic [NCH*DATA_W-1:0]   in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [NCH*DATA_W-1:0]   out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/down_fir.sv
// rtl/down_fir.sv - multichannel decimating FIR, one MAC per cycle over a shared coefficient table
module down_fir #(
  parameter int DATA_W = 24,
  parameter int COEF_W = 32,
  parameter int NCH    = 2,
  parameter int AW     = 7,
  parameter int ACC_W  = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [AW:0]              ntap,
  input  logic [3:0]               dec,
  input  logic                     coef_bank,
  down_fir_if.slave                bus,
  output logic [AW-1:0]            coef_addr,
  output logic                     coef_sel,
  input  logic signed [COEF_W-1:0] coef,
  output logic                     busy
);
  localparam int DEPTH = 1 << AW;
  localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW    = DATA_W + COEF_W;
  localparam logic [AW:0] DEPTH_V = {1'b1, {AW{1'b0}}};
  localparam logic signed [ACC_W-1:0] RND     = ACC_W'(1) << (COEF_W - 2);
  localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) << (DATA_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -(ACC_W'(1) << (DATA_W - 1));

  typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} state_t;

  state_t                    state;
  logic [AW-1:0]             wp;
  logic [AW-1:0]             base;
  logic [3:0]                phase;
  logic [AW:0]               fill;
  logic [AW:0]               n_eff;
  logic [CW-1:0]             ch;
  logic signed [ACC_W-1:0]   acc;
  logic [DATA_W-1:0]         res [NCH];
  logic [NCH*DATA_W-1:0]     out_data_q;
  logic                      out_valid_q;
  logic [DATA_W-1:0]         hist [NCH][DEPTH];

  logic                      accept;
  logic [3:0]                d_eff;
  logic [AW:0]               n_clamp;
  logic [AW-1:0]             rd_idx;
  logic signed [DATA_W-1:0]  sample;
  logic signed [PW-1:0]      prod;
  logic signed [ACC_W-1:0]   acc_next;
  logic signed [ACC_W-1:0]   rnd;
  logic signed [ACC_W-1:0]   shifted;
  logic [DATA_W-1:0]         ch_res;
  logic                      last_tap;

  assign bus.in_ready  = rst_n && (state == IDLE) && !flush;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign busy          = (state != IDLE);
  assign accept        = bus.in_valid && bus.in_ready;
  assign d_eff         = (dec == 4'd0) ? 4'd1 : dec;

  always_comb begin
    n_clamp = ntap;
    if (ntap == '0)
      n_clamp = (AW+1)'(1);
    else if (ntap > DEPTH_V)
      n_clamp = DEPTH_V;
  end

  // Tap k walks backwards from the newest frame; taps older than the fill level read as zero.
  assign rd_idx   = base - coef_addr;
  assign sample   = ({1'b0, coef_addr} < fill) ? hist[ch][rd_idx] : '0;
  assign prod     = $signed({{COEF_W{sample[DATA_W-1]}}, sample}) *
                    $signed({{DATA_W{coef[COEF_W-1]}}, coef});
  assign acc_next = acc + {{(ACC_W-PW){prod[PW-1]}}, prod};
  assign rnd      = acc_next + RND;
  assign shifted  = rnd >>> (COEF_W - 1);
  assign last_tap = ({1'b0, coef_addr} == (n_eff - (AW+1)'(1)));

  always_comb begin
    ch_res = shifted[DATA_W-1:0];
    if (shifted > SAT_MAX)
      ch_res = SAT_MAX[DATA_W-1:0];
    else if (shifted < SAT_MIN)
      ch_res = SAT_MIN[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int c = 0; c < NCH; c++)
        hist[c][wp] <= bus.in_data[c*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wp          <= '0;
      base        <= '0;
      phase       <= '0;
      fill        <= '0;
      n_eff       <= (AW+1)'(1);
      ch          <= '0;
      acc         <= '0;
      coef_addr   <= '0;
      coef_sel    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int c = 0; c < NCH; c++)
        res[c] <= '0;
    end else if (flush) begin
      state       <= IDLE;
      wp          <= '0;
      phase       <= '0;
      fill        <= '0;
      acc         <= '0;
      ch          <= '0;
      coef_addr   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            wp   <= wp + AW'(1);
            base <= wp;
            if (fill != DEPTH_V)
              fill <= fill + (AW+1)'(1);
            // A frame landing on the last phase of the decimation window starts a filter run.
            if (phase >= d_eff - 4'd1) begin
              phase     <= '0;
              state     <= MAC;
              n_eff     <= n_clamp;
              coef_sel  <= coef_bank;
              coef_addr <= '0;
              ch        <= '0;
              acc       <= '0;
            end else begin
              phase <= phase + 4'd1;
            end
          end
        end
        MAC: begin
          if (last_tap) begin
            res[ch]   <= ch_res;
            acc       <= '0;
            coef_addr <= '0;
            if (ch == CW'(NCH - 1))
              state <= ROUND;
            else
              ch <= ch + CW'(1);
          end else begin
            acc       <= acc_next;
            coef_addr <= coef_addr + AW'(1);
          end
        end
        ROUND: begin
          for (int c = 0; c < NCH; c++)
            out_data_q[c*DATA_W +: DATA_W] <= res[c];
          out_valid_q <= 1'b1;
          state       <= OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_down_fir.sv
// tb/tb_down_fir.sv - directed and randomized checks of down_fir against a frame-history model
module tb_down_fir;
  localparam int DW  = 24;
  localparam int CWD = 32;
  localparam int NCH = 2;
  localparam int AW  = 7;
  localparam int FW  = NCH * DW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic [AW:0]       ntap;
  logic [3:0]        dec;
  logic              coef_bank;
  logic [AW-1:0]     coef_addr;
  logic              coef_sel;
  logic signed [CWD-1:0] coef;
  logic              busy;

  logic signed [CWD-1:0] coef_tab [2][128];
  logic [FW-1:0]     fq [$];
  logic [FW-1:0]     imp [2][5];
  logic [FW-1:0]     got;
  logic [FW-1:0]     sat_exp;
  int n_cmp = 0;
  int n_bad = 0;
  int n_frames = 0;
  int n_out = 0;
  int d_model = 1;
  int n_model = 4;

  down_fir_if #(.NCH(NCH), .DATA_W(DW)) bus();

  down_fir #(.DATA_W(DW), .COEF_W(CWD), .NCH(NCH), .AW(AW), .ACC_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .ntap(ntap), .dec(dec),
    .coef_bank(coef_bank), .bus(bus), .coef_addr(coef_addr),
    .coef_sel(coef_sel), .coef(coef), .busy(busy)
  );

  always #5 clk = ~clk;

  assign coef = coef_tab[coef_sel][coef_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output = round-and-saturate of sum over the last n frames, newest first, zeros before history start.
  function automatic logic [FW-1:0] model(input int n, input logic bank);
    logic [FW-1:0] r;
    logic signed [DW-1:0] s;
    longint acc;
    int len;
    r = '0;
    len = fq.size();
    for (int c = 0; c < NCH; c++) begin
      acc = 0;
      for (int k = 0; k < n && k < len; k++) begin
        s = fq[len-1-k][c*DW +: DW];
        acc += longint'(s) * longint'(coef_tab[bank][k]);
      end
      acc = (acc + (longint'(1) <<< 30)) >>> 31;
      if (acc > 64'sd8388607) acc = 64'sd8388607;
      else if (acc < -64'sd8388608) acc = -64'sd8388608;
      r[c*DW +: DW] = acc[DW-1:0];
    end
    return r;
  endfunction

  function automatic logic [FW-1:0] rnd_frame();
    return {16'($urandom), 32'($urandom)};
  endfunction

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_ready_low", 64'(bus.in_ready), 64'd0);
    flush = 1'b0;
    #1;
    fq.delete();
    n_frames = 0;
    n_out = 0;
  endtask

  task automatic frame(input logic [FW-1:0] d, input logic bank, input int hold, output logic [FW-1:0] o);
    int t;
    logic [FW-1:0] exp;
    t = 0;
    coef_bank = bank;
    bus.in_data = d;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && t < 5000) begin @(posedge clk); #1; t++; end
    chk("in_ready_wait", 64'(t < 5000), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    coef_bank = 1'($urandom);
    fq.push_back(d);
    n_frames++;
    o = '0;
    if ((n_frames % d_model) == 0) begin
      chk("coef_sel", 64'(coef_sel), 64'(bank));
      chk("busy_mac", 64'(busy), 64'd1);
      exp = model(n_model, bank);
      t = 0;
      while (!bus.out_valid && t < 5000) begin @(posedge clk); #1; t++; end
      if (bus.out_valid) n_out++;
      chk("latency", 64'(t), 64'(NCH * n_model + 1));
      chk("out_data", 64'(bus.out_data), 64'(exp));
      o = bus.out_data;
      bus.in_valid = (hold > 0);
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        chk("bp_valid", 64'(bus.out_valid), 64'd1);
        chk("bp_data", 64'(bus.out_data), 64'(o));
        chk("bp_ready", 64'(bus.in_ready), 64'd0);
        chk("bp_busy", 64'(busy), 64'd1);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b0;
      chk("out_done", 64'(bus.out_valid), 64'd0);
    end else begin
      repeat (3) @(posedge clk);
      #1;
      chk("no_out", 64'({bus.out_valid, busy}), 64'd0);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_data = '0;
    ntap = 8'd4;
    dec = 4'd1;
    coef_bank = 1'b0;
    for (int k = 0; k < 128; k++) begin
      coef_tab[0][k] = 32'sh40000000;
      coef_tab[1][k] = $urandom;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_coef_addr", 64'(coef_addr), 64'd0);
    chk("rst_coef_sel", 64'(coef_sel), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", 64'(bus.in_ready), 64'd1);

    // Impulse run, then flush mid-MAC, then repeat impulse run.
    for (int run = 0; run < 2; run++) begin
      for (int i = 0; i < 5; i++) begin
        frame((i == 0) ? FW'(1000) : FW'(0), 1'b0, 0, got);
        imp[run][i] = got;
        chk("imp_ch0", 64'(got[DW-1:0]), (i < 4) ? 64'd500 : 64'd0);
        chk("imp_ch1", 64'(got[FW-1:DW]), 64'd0);
      end
      if (run == 0) begin
        bus.in_data = FW'(1000);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mac_cycle3_busy", 64'(busy), 64'd1);
        do_flush();
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_ready_back", 64'(bus.in_ready), 64'd1);
      end
    end
    for (int i = 0; i < 5; i++)
      chk("imp_repeat", 64'(imp[1][i]), 64'(imp[0][i]));

    // Decimation by 2, then dec=0 acting as 1.
    do_flush();
    dec = 4'd2; d_model = 2;
    for (int i = 0; i < 6; i++) frame(rnd_frame(), 1'b1, 0, got);
    chk("dec2_count", 64'(n_out), 64'd3);
    do_flush();
    dec = 4'd0; d_model = 1;
    for (int i = 0; i < 3; i++) frame(rnd_frame(), 1'b1, 0, got);
    chk("dec0_count", 64'(n_out), 64'd3);

    // Saturation both ways.
    for (int k = 0; k < 128; k++) coef_tab[0][k] = 32'sh7FFFFFFF;
    do_flush();
    for (int i = 0; i < 4; i++) frame({24'h7FFFFF, 24'h7FFFFF}, 1'b0, 0, got);
    sat_exp = {24'h7FFFFF, 24'h7FFFFF};
    chk("sat_pos", 64'(got), 64'(sat_exp));
    do_flush();
    for (int i = 0; i < 4; i++) frame({24'h800000, 24'h800000}, 1'b0, 0, got);
    sat_exp = {24'h800000, 24'h800000};
    chk("sat_neg", 64'(got), 64'(sat_exp));

    // Backpressure with random coefficients.
    for (int k = 0; k < 128; k++) coef_tab[0][k] = $urandom;
    do_flush();
    frame(rnd_frame(), 1'b0, 10, got);
    frame(rnd_frame(), 1'b1, 10, got);

    // Tap-count clamping at both ends.
    do_flush();
    ntap = 8'd0; n_model = 1;
    for (int i = 0; i < 3; i++) frame(rnd_frame(), 1'b0, 0, got);
    ntap = 8'd200; n_model = 128;
    for (int i = 0; i < 3; i++) frame(rnd_frame(), 1'b1, 0, got);

    // Long run past the write-pointer wrap with full-length filter.
    do_flush();
    ntap = 8'd128; n_model = 128;
    for (int i = 0; i < 300; i++) frame(rnd_frame(), 1'b0, 0, got);
    chk("wrap_count", 64'(n_out), 64'd300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
